sr_fetch_sequencer: RTL and testbench

//  Issues instructions one at a time to the single-issue decode/execute datapath from 64-bit fetch pairs (slot0 @ base, slot1 @ base+4).

---
 rtl/sr_fetch_sequencer_pkg.sv | 16 +
 rtl/sr_fetch_sequencer_stats.sv | 38 +++
 rtl/sr_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_sr_fetch_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sr_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
// State encoding for the pair-issue FSM and the RISC-V canonical NOP.
// Imported by sr_fetch_sequencer.
package sr_fetch_sequencer_pkg;

  // EMPTY: no pair held; SLOT0/SLOT1: issuing that word of the held pair.
  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,
    FS_SLOT0 = 2'd1,
    FS_SLOT1 = 2'd2
  } fsState_t;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sr_fetch_sequencer_stats.sv
// Purpose: three saturating event counters for the fetch sequencer.
// Latency: counts are visible the cycle after the counted event edge.
// Backpressure: none; every input is sampled every cycle.
// Ports: clk, rst_n; issueFire/bubble/redirect event strobes;
//        stat_issued/stat_bubbles/stat_redirects counter outputs (CNT_W bits).
module sr_fetch_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issueFire,
  input  logic             bubble,
  input  logic             redirect,
  output logic [CNT_W-1:0] stat_issued,
  output logic [CNT_W-1:0] stat_bubbles,
  output logic [CNT_W-1:0] stat_redirects
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued    <= '0;
      stat_bubbles   <= '0;
      stat_redirects <= '0;
    end else begin
      // Each counter sticks at all-ones instead of wrapping.
      if (issueFire && stat_issued != CNT_MAX)
        stat_issued <= stat_issued + CNT_ONE;
      if (bubble && stat_bubbles != CNT_MAX)
        stat_bubbles <= stat_bubbles + CNT_ONE;
      if (redirect && stat_redirects != CNT_MAX)
        stat_redirects <= stat_redirects + CNT_ONE;
    end
  end

endmodule

// File: rtl/sr_fetch_sequencer.sv
// Purpose: issues single instructions from 64-bit fetch pairs, owns fetch PC, applies redirects.
// Latency: a pair loaded at edge N issues its first word from cycle N+1; 1 instr/cycle when streaming.
// Backpressure: issue_ready=0 freezes issue_*, state and fetch_addr; fetch_req drops while a word is pending.
// Ports: clk, rst_n; fetch_addr/fetch_req out, fetch_valid/fetch_data0/fetch_data1 in;
//        issue_valid/issue_instr/issue_pc out, issue_ready in; redirect_valid/redirect_pc in;
//        stat_issued/stat_bubbles/stat_redirects out only when SR_FETCH_SEQ_STATS_EN is defined.
module sr_fetch_sequencer
  import sr_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      fetch_addr,
  output logic             fetch_req,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_data0,
  input  logic [31:0]      fetch_data1,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [31:0]      issue_instr,
  output logic [31:0]      issue_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc
`ifdef SR_FETCH_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_issued,
  output logic [CNT_W-1:0] stat_bubbles,
  output logic [CNT_W-1:0] stat_redirects
`endif
);

  fsState_t    state;
  logic [31:0] slot1Word;  // second word of the held pair, issued after slot0
  logic        skip1;      // pending redirect targeted the odd word of its pair
  logic        load;

  // Targets are word aligned; the low two bits carry no information.
  logic unusedRedirectLsbs;
  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  assign issue_valid = (state != FS_EMPTY);
  assign fetch_req   = (state == FS_EMPTY) || (state == FS_SLOT1 && issue_ready);
  assign load        = fetch_req && fetch_valid && !redirect_valid;

  // issue_instr/issue_pc are loaded directly on each transition so the
  // decoder sees flop outputs with no path back to the fetch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_EMPTY;
      fetch_addr  <= RESET_PC;
      slot1Word   <= RV_NOP;
      skip1       <= 1'b0;
      issue_instr <= RV_NOP;
      issue_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      // Held pair and any same-cycle load are discarded.
      state      <= FS_EMPTY;
      fetch_addr <= {redirect_pc[31:3], 3'b000};
      skip1      <= redirect_pc[2];
    end else if (load) begin
      slot1Word  <= fetch_data1;
      fetch_addr <= fetch_addr + 32'd8;
      skip1      <= 1'b0;
      // skip1 can only be set while EMPTY, so a load from SLOT1 always lands in SLOT0.
      if (skip1) begin
        state       <= FS_SLOT1;
        issue_instr <= fetch_data1;
        issue_pc    <= fetch_addr + 32'd4;
      end else begin
        state       <= FS_SLOT0;
        issue_instr <= fetch_data0;
        issue_pc    <= fetch_addr;
      end
    end else if (issue_ready) begin
      case (state)
        FS_SLOT0: begin
          state       <= FS_SLOT1;
          issue_instr <= slot1Word;
          issue_pc    <= issue_pc + 32'd4;
        end
        FS_SLOT1: state <= FS_EMPTY;
        default:  state <= state;
      endcase
    end
  end

`ifdef SR_FETCH_SEQ_STATS_EN
  sr_fetch_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .issueFire      (issue_valid && issue_ready),
    .bubble         (!issue_valid),
    .redirect       (redirect_valid),
    .stat_issued    (stat_issued),
    .stat_bubbles   (stat_bubbles),
    .stat_redirects (stat_redirects)
  );
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_sr_fetch_sequencer.sv
// Directed bench for sr_fetch_sequencer: reset, streaming, backpressure,
// redirects (odd target, back-to-back), fetch stall, mid-run reset, and
// counters when SR_FETCH_SEQ_STATS_EN is defined.
module tb_sr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        fetch_valid;
  logic [31:0] fetch_data0;
  logic [31:0] fetch_data1;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef SR_FETCH_SEQ_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_bubbles;
  logic [31:0] stat_redirects;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word holds 0xC0DE0000 + its own byte address.
  assign fetch_data0 = 32'hC0DE_0000 + fetch_addr;
  assign fetch_data1 = 32'hC0DE_0000 + fetch_addr + 32'd4;

  sr_fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_addr     (fetch_addr),
    .fetch_req      (fetch_req),
    .fetch_valid    (fetch_valid),
    .fetch_data0    (fetch_data0),
    .fetch_data1    (fetch_data1),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_instr    (issue_instr),
    .issue_pc       (issue_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef SR_FETCH_SEQ_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_bubbles   (stat_bubbles),
    .stat_redirects (stat_redirects)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issueIs(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
    chk({tag, "_instr"}, issue_instr, instr);
    chk({tag, "_pc"}, issue_pc, pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_valid    = 1'b0;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // 1 Reset values
    @(negedge clk);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd1);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_issue_instr", issue_instr, 32'h0000_0013);
    chk("rst_issue_pc", issue_pc, 32'h0);

    // 2 Streaming: two pairs, one instruction per cycle
    rst_n       = 1'b1;
    fetch_valid = 1'b1;
    issue_ready = 1'b1;
    @(negedge clk);
    issueIs("s_a0", 32'hC0DE_0000, 32'h0);
    chk("s_a0_req", {31'd0, fetch_req}, 32'd0);
    chk("s_a0_addr", fetch_addr, 32'h8);
    @(negedge clk);
    issueIs("s_a1", 32'hC0DE_0004, 32'h4);
    chk("s_a1_req", {31'd0, fetch_req}, 32'd1);
    @(negedge clk);
    issueIs("s_b0", 32'hC0DE_0008, 32'h8);
    @(negedge clk);
    issueIs("s_b1", 32'hC0DE_000C, 32'hC);
    chk("s_b1_addr", fetch_addr, 32'h10);
    @(negedge clk);
    issueIs("s_c0", 32'hC0DE_0010, 32'h10);

    // 4 Redirect to odd word 0x24 while slot0 of pair@0x10 is consumed
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0024;
    @(negedge clk);
    chk("rd_valid", {31'd0, issue_valid}, 32'd0);
    chk("rd_addr", fetch_addr, 32'h20);
    chk("rd_req", {31'd0, fetch_req}, 32'd1);
    redirect_valid = 1'b0;
    @(negedge clk);
    issueIs("rd_tgt", 32'hC0DE_0024, 32'h24);
    chk("rd_tgt_addr", fetch_addr, 32'h28);
    @(negedge clk);
    issueIs("bp_pre", 32'hC0DE_0028, 32'h28);

    // 3 Backpressure for 3 cycles in SLOT0, then resume with slot1
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_instr", issue_instr, 32'hC0DE_0028);
      chk("bp_pc", issue_pc, 32'h28);
      chk("bp_req", {31'd0, fetch_req}, 32'd0);
      chk("bp_addr", fetch_addr, 32'h30);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issueIs("bp_resume", 32'hC0DE_002C, 32'h2C);

    // 5 Fetch stall when SLOT1 is consumed
    fetch_valid = 1'b0;
    @(negedge clk);
    chk("st_valid0", {31'd0, issue_valid}, 32'd0);
    chk("st_req", {31'd0, fetch_req}, 32'd1);
    chk("st_addr", fetch_addr, 32'h30);
    @(negedge clk);
    chk("st_valid1", {31'd0, issue_valid}, 32'd0);
    fetch_valid = 1'b1;
    @(negedge clk);
    issueIs("st_resume", 32'hC0DE_0030, 32'h30);
    chk("st_resume_addr", fetch_addr, 32'h38);

    // Back-to-back redirects: second (even target) wins and clears skip1
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0044;
    @(negedge clk);
    chk("b2b_addr0", fetch_addr, 32'h40);
    redirect_pc = 32'h0000_0050;
    @(negedge clk);
    chk("b2b_addr1", fetch_addr, 32'h50);
    chk("b2b_valid", {31'd0, issue_valid}, 32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    issueIs("b2b_tgt", 32'hC0DE_0050, 32'h50);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("mrst_addr", fetch_addr, 32'h0);
    chk("mrst_valid", {31'd0, issue_valid}, 32'd0);
    chk("mrst_instr", issue_instr, 32'h0000_0013);
    chk("mrst_pc", issue_pc, 32'h0);

`ifdef SR_FETCH_SEQ_STATS_EN
    // 6 Counters: stream of 4, 2 stall cycles, 1 redirect
    @(negedge clk);
    rst_n          = 1'b1;
    fetch_valid    = 1'b1;
    issue_ready    = 1'b1;
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    fetch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("stat_issued", stat_issued, 32'd4);
    chk("stat_bubbles", stat_bubbles, 32'd3);
    chk("stat_redirects", stat_redirects, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
